// File: rtl/dht_onewire_reader_if.sv
// ---------------------------------------------------------------------------
// dht_onewire_reader_if
//
// Handshake and result bundle between the DHT single-wire reader and the
// command layer that requests reads.
//
// Signals:
//   start    : read request from the command layer (sampled in IDLE only)
//   busy     : transaction in progress
//   done     : one-cycle pulse at the end of every transaction
//   data     : last good frame, first received bit in data[NUM_BITS-1]
//   err      : last transaction failed (holds until the next accepted start)
//   err_code : 0 ok, 1 no response / bus fault, 2 bit timeout, 3 checksum
//
// Modports:
//   master : command layer side (drives start)
//   slave  : reader side (drives busy/done/data/err/err_code)
// ---------------------------------------------------------------------------
interface dht_onewire_reader_if #(
    parameter int NUM_BITS = 40
);
    logic                start;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] data;
    logic                err;
    logic [1:0]          err_code;

    modport master (
        output start,
        input  busy,
        input  done,
        input  data,
        input  err,
        input  err_code
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output data,
        output err,
        output err_code
    );
endinterface

// File: rtl/dht_onewire_reader.sv
// ---------------------------------------------------------------------------
// dht_onewire_reader
//
// Single-wire reader for DHT11/DHT22-class sensors on a 1 MHz timebase.
// Generates the host start pulse, checks the sensor acknowledge, decodes
// NUM_BITS pulse-width-coded bits and reports the frame through a
// start/busy/done handshake with an error code.
//
// Ports:
//   clock_1M : 1 MHz clock (1 cycle = 1 us)
//   reset    : asynchronous, active-low reset
//   dht_io   : open-drain sensor line, external pull-up; only ever driven 0
//   bus      : dht_onewire_reader_if.slave (start, busy, done, data, err,
//              err_code)
//
// Optional feature:
//   DHT_CHECKSUM_EN : when defined, CHECK verifies byte4 against the mod-256
//                     sum of bytes 0..3 (byte0 = data[39:32]) and reports
//                     err_code 3 on mismatch. Only valid for NUM_BITS = 40.
//                     When undefined, every complete frame is accepted.
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for start, line released
//   S_START_LOW | host drives the line low for START_LOW_US cycles
//   S_RELEASE   | line released for RELEASE_US cycles
//   S_ACK_LOW   | waiting for sensor to pull the line low
//   S_ACK_HIGH  | waiting for sensor acknowledge high phase
//   S_ACK_END   | waiting for the low phase that opens bit 0
//   S_BIT_LOW   | low phase of a bit, waiting for the rising edge
//   S_BIT_HIGH  | measuring the high phase of a bit
//   S_CHECK     | frame complete, validate and publish
//   S_DONE      | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module dht_onewire_reader #(
    parameter int START_LOW_US  = 19000,
    parameter int RELEASE_US    = 20,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 1000,
    parameter int NUM_BITS      = 40,
    parameter int CNT_W         = 16
) (
    input  logic                   clock_1M,
    input  logic                   reset,
    inout  wire                    dht_io,
    dht_onewire_reader_if.slave    bus
);

    localparam int IDX_W = $clog2(NUM_BITS + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_US - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_US - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] BIT_THRESH   = CNT_W'(BIT_THRESH_US);
    localparam logic [IDX_W-1:0] LAST_BIT     = IDX_W'(NUM_BITS - 1);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_BUS = 2'd1;
    localparam logic [1:0] ERR_BIT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_ACK_LOW,
        S_ACK_HIGH,
        S_ACK_END,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [NUM_BITS-1:0] shadow;
    logic [NUM_BITS-1:0] data_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          err_code_q;
    logic                drive_low;
    logic                s_meta;
    logic                s_io;

    // drive_low has an async clear, so reset releases the line immediately.
    assign dht_io = drive_low ? 1'b0 : 1'bz;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data     = data_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

    // Synchroniser resets to the idle (pulled-up) level so the first sample
    // after reset is not mistaken for a bus fault.
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b1;
            s_io   <= 1'b1;
        end else begin
            s_meta <= dht_io;
            s_io   <= s_meta;
        end
    end

`ifdef DHT_CHECKSUM_EN
    localparam logic [1:0] ERR_SUM = 2'd3;

    generate
        if (NUM_BITS != 40) begin : g_num_bits_check
            $error("dht_onewire_reader: DHT_CHECKSUM_EN requires NUM_BITS = 40");
        end
    endgenerate

    logic [7:0] sum;
    logic       chk_ok;

    always_comb begin
        sum    = shadow[39:32] + shadow[31:24] + shadow[23:16] + shadow[15:8];
        chk_ok = (sum == shadow[7:0]);
    end
`endif

    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shadow     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OK;
            drive_low  <= 1'b0;
        end else begin
            // Counter runs by default; every state change below clears it.
            cnt    <= cnt + 1'b1;
            done_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.start) begin
                        if (s_io) begin
                            state      <= S_START_LOW;
                            busy_q     <= 1'b1;
                            drive_low  <= 1'b1;
                            err_q      <= 1'b0;
                            err_code_q <= ERR_OK;
                            shadow     <= '0;
                        end else begin
                            // Line already low before we touched it.
                            state      <= S_DONE;
                            done_q     <= 1'b1;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_BUS;
                        end
                    end
                end

                S_START_LOW: begin
                    if (cnt == START_LAST) begin
                        state     <= S_RELEASE;
                        cnt       <= '0;
                        drive_low <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    if (cnt == RELEASE_LAST) begin
                        state <= S_ACK_LOW;
                        cnt   <= '0;
                    end
                end

                S_ACK_LOW: begin
                    if (!s_io) begin
                        state <= S_ACK_HIGH;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BUS;
                    end
                end

                S_ACK_HIGH: begin
                    if (s_io) begin
                        state <= S_ACK_END;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BUS;
                    end
                end

                S_ACK_END: begin
                    if (!s_io) begin
                        state   <= S_BIT_LOW;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BUS;
                    end
                end

                S_BIT_LOW: begin
                    if (s_io) begin
                        state <= S_BIT_HIGH;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BIT;
                    end
                end

                S_BIT_HIGH: begin
                    if (!s_io) begin
                        // Both edges pass the same synchroniser, so cnt is the
                        // high width less one; the threshold absorbs that.
                        shadow <= {shadow[NUM_BITS-2:0], (cnt >= BIT_THRESH)};
                        cnt    <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_CHECK;
                        end else begin
                            state   <= S_BIT_LOW;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BIT;
                    end
                end

                S_CHECK: begin
`ifdef DHT_CHECKSUM_EN
                    if (chk_ok) begin
                        data_q <= shadow;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_SUM;
                    end
`else
                    data_q <= shadow;
`endif
                    state  <= S_DONE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end

                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end

                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    busy_q    <= 1'b0;
                    drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule
